// File: rtl/signed_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : signed_alu_seq
// Description : Handshaked signed ALU. ADD/SUB/CMP finish in one cycle,
//               MUL runs an iterative signed shift-add (one partial product
//               per cycle, MSB partial product subtracted). Optional
//               saturation to the WIDTH-bit signed range, overflow flag and
//               lt/gt/eq compare flags for the accepted operand pair.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic               sat,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf,
    output logic               lt,
    output logic               gt,
    output logic               eq
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_SW-1:0] c_LAST = c_SW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_MUL = 2'd2;
    localparam logic [1:0] c_OP_CMP = 2'd3;

    // Largest / smallest WIDTH-bit signed values, sign-extended to 2*WIDTH
    localparam logic [c_PW-1:0] c_MAX_PW = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [c_PW-1:0] c_MIN_PW = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_SW-1:0] r_step;
    logic            r_sat;
    logic [c_PW-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_PW-1:0] r_acc;
    logic [c_PW-1:0] r_result;
    logic            r_ovf;
    logic            r_lt;
    logic            r_gt;
    logic            r_eq;

    logic            w_accept;
    logic [WIDTH:0]  w_ax;
    logic [WIDTH:0]  w_bx;
    logic [WIDTH:0]  w_sum;
    logic            w_as_ovf;
    logic [c_PW-1:0] w_as_res;
    logic [c_PW-1:0] w_addend;
    logic [c_PW-1:0] w_prod;
    logic [WIDTH:0]  w_prod_top;
    logic            w_mul_ovf;
    logic [c_PW-1:0] w_mul_res;

    assign w_accept = in_valid && in_ready;

    // ADD/SUB: exact value in WIDTH+1 bits, then wrap or clamp
    always_comb begin
        w_ax  = {a[WIDTH-1], a};
        w_bx  = {b[WIDTH-1], b};
        w_sum = (op == c_OP_SUB) ? (w_ax - w_bx) : (w_ax + w_bx);
        // Top two bits disagree exactly when the value left the WIDTH-bit range
        w_as_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
        if (w_as_ovf && sat) begin
            w_as_res = w_sum[WIDTH] ? c_MIN_PW : c_MAX_PW;
        end else begin
            w_as_res = {{WIDTH{w_sum[WIDTH-1]}}, w_sum[WIDTH-1:0]};
        end
    end

    // MUL step: add the shifted multiplicand, or subtract it on the MSB step
    // since the multiplier's top bit carries weight -2^(WIDTH-1)
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = (r_step == c_LAST) ? (~r_mcand + 1'b1) : r_mcand;
        end
        w_prod     = r_acc + w_addend;
        w_prod_top = w_prod[c_PW-1:WIDTH-1];
        // Product fits WIDTH bits only if its upper WIDTH+1 bits are all equal
        w_mul_ovf  = !((&w_prod_top) || (~|w_prod_top));
        if (w_mul_ovf && r_sat) begin
            w_mul_res = w_prod[c_PW-1] ? c_MIN_PW : c_MAX_PW;
        end else begin
            w_mul_res = w_prod;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_next = (op == c_OP_MUL) ? c_BUSY : c_DONE;
                end
            end
            c_BUSY: begin
                if (r_step == c_LAST) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    // Datapath: capture on accept, iterate multiply in BUSY, hold in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step   <= '0;
            r_sat    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_lt     <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if (w_accept) begin
            r_sat <= sat;
            r_lt  <= ($signed(a) <  $signed(b));
            r_gt  <= ($signed(a) >  $signed(b));
            r_eq  <= (a == b);
            case (op)
                c_OP_ADD, c_OP_SUB: begin
                    r_result <= w_as_res;
                    r_ovf    <= w_as_ovf;
                end
                c_OP_MUL: begin
                    r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
                    r_mplier <= b;
                    r_acc    <= '0;
                    r_step   <= '0;
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                end
                c_OP_CMP: begin
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                end
                default: begin
                    r_result <= '0;
                    r_ovf    <= 1'b0;
                end
            endcase
        end else if (r_state == c_BUSY) begin
            r_acc    <= w_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_step == c_LAST) begin
                r_step   <= '0;
                r_result <= w_mul_res;
                r_ovf    <= w_mul_ovf;
            end else begin
                r_step <= r_step + 1'b1;
            end
        end
    end

    assign result = r_result;
    assign ovf    = r_ovf;
    assign lt     = r_lt;
    assign gt     = r_gt;
    assign eq     = r_eq;

endmodule
`default_nettype wire

// File: doc/signed_alu_seq.md
# signed_alu_seq

Parametrised, handshaked signed arithmetic unit: the sequential successor to the combinational signed add/sub/multiply/compare block. It accepts one operand pair plus opcode per transaction, computes add, subtract, multiply (iterative shift-add, one partial product per cycle) or compare in two's complement, with optional saturation and an overflow flag. It sits between a valid/ready producer and consumer in the datapath, so a wide multiply does not need a full combinational array.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair and opcode valid
- in_ready  out  1  unit can accept a transaction
- op  in  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 CMP
- sat  in  1  1 = saturate result to the WIDTH-bit signed range; 0 = wrap
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  2*WIDTH  signed result
- ovf  out  1  true result outside the WIDTH-bit signed range (ADD/SUB/MUL); 0 for CMP
- lt, gt, eq  out  1 each  signed a<b, a>b, a==b for the accepted pair

## Operation
- States: IDLE, BUSY, DONE. Reset forces IDLE.
- IDLE: in_ready=1. An accept occurs when in_valid and in_ready are both high.
  - On accept, latch a, b, op and sat, and compute lt, gt and eq from the operands.
  - ADD, SUB or CMP go to DONE.
  - MUL loads the multiplier and accumulator, then goes to BUSY.
- BUSY: in_ready=0. Run one shift-add step per cycle for WIDTH cycles total (step counter 0..WIDTH-1).
  - Signed handling: subtract the multiplicand at the MSB step (Booth-free signed correction), or use magnitude multiply with a final sign fix. Either way the product must be exact over 2*WIDTH bits.
  - After the last step, go to DONE.
- DONE: out_valid=1 and in_ready=0. result, ovf and the flags are held stable until out_ready=1, then go to IDLE.
- ADD/SUB:
  - Compute the true value in WIDTH+1 bits. ovf=1 if it is outside [-2^(W-1), 2^(W-1)-1].
  - sat=0: result is the low WIDTH bits sign-extended to 2*WIDTH (wrapped value).
  - sat=1: result is clamped to max or min, then sign-extended.
- MUL:
  - The exact product lies in 2*WIDTH bits. ovf=1 if the product is outside the WIDTH-bit signed range.
  - sat=0: result is the exact 2*WIDTH product (no wrap).
  - sat=1: result is clamped to the WIDTH-bit range, then sign-extended.
- CMP: result=0, ovf=0, and only the flags carry information.
- Flags lt, gt and eq always reflect the accepted pair; exactly one is 1 after any transaction.
- Inputs other than out_ready are ignored outside IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, ovf=0, lt=0, gt=0, eq=0, state IDLE, step counter 0.
- Asynchronous reset mid-operation (BUSY or DONE) abandons the transaction. On the first edge after deassertion, the unit is IDLE and can accept.
- Latency from the accept edge k to out_valid high:
  - ADD/SUB/CMP: out_valid is high after edge k+1.
  - MUL: out_valid is high after edge k+WIDTH+1 (WIDTH BUSY cycles).
- Handshake:
  - The result transfers on the edge where out_valid and out_ready are both high. out_valid drops after that edge.
  - in_ready rises in the same cycle; there is no same-cycle accept and retire.
  - Throughput for ADD/SUB/CMP is one transaction every 2 cycles when out_ready=1.
- out_ready held high before the result arrives: the result retires on the first DONE cycle.
- out_ready low: DONE persists indefinitely with all outputs frozen.
- in_valid held high while not ready: no accept, and a/b may change without effect.

## Test plan
- WIDTH=8, ADD a=100, b=27, sat=0 -> result=127, ovf=0, gt=1. Then ADD a=100, b=28 -> result=0xFF80 (-128), ovf=1. Same with sat=1 -> result=127, ovf=1.
- SUB a=-128, b=1: sat=0 -> result=127, ovf=1; sat=1 -> result=-128 (0xFF80), ovf=1, lt=1.
- MUL a=-128, b=-128: sat=0 -> result=16384 (0x4000), ovf=1; sat=1 -> result=127. MUL a=-7, b=9 -> result=-63 (0xFFC1), ovf=0. out_valid rises exactly 9 cycles after the accept edge.
- CMP over pairs (-1,1), (1,-1), (-5,-5) -> (lt,gt,eq) = 100, 010, 001, with result=0 and ovf=0.
- Backpressure: out_ready=0 for 10 cycles after a MUL completes -> result stable, in_ready=0, new in_valid pulses ignored. out_ready=1 -> retires in one cycle, then the next operation is accepted.
- Assert rst_n low at BUSY step 4 of a MUL -> all outputs go to reset values immediately. After release, ADD 3+4 gives result=7 after 2 cycles.
